mu0_uart_tx: RTL and testbench
==============================

MU0_UART_TX -- requirements
Module: mu0_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 16, Clk cycles per serial bit (legal range 2..65535).
REQ-002 The block SHALL have parameter BASE_ADDR, default 12'hFF0, first word of a 4-word register window.
REQ-003 The block SHALL have port Clk  input  1  system clock; all state changes on rising edge.
REQ-004 The block SHALL have port Reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port Address  input  12  MU0 bus word address.
REQ-006 The block SHALL have port Data_out  input  16  MU0 write data (CPU to peripheral).
REQ-007 The block SHALL have port Rd  input  1  MU0 read strobe.
REQ-008 The block SHALL have port Wr  input  1  MU0 write strobe.
REQ-009 The block SHALL have port Data_in  output  16  read data to CPU.
REQ-010 The block SHALL have port Sel  output  1  high when Address is inside the window, for top-level read-data muxing.
REQ-011 The block SHALL have port Tx  output  1  serial line, idle high.

Function
REQ-012 Window decode SHALL be Address[11:2] == BASE_ADDR[11:2]; Sel = decode, combinational.
REQ-013 Register map SHALL be: +0 TXDATA (write-only); +1 STATUS (read-only); +2 CTRL (read/write); +3 reserved (reads 0, writes ignored).
REQ-014 Reads SHALL be combinational: Data_in = selected register when Rd & Sel, else 16'h0000.
REQ-015 Writes SHALL take effect on the rising Clk edge where Wr & Sel; Wr & Rd both high SHALL be treated as a write.
REQ-016 A TXDATA write SHALL push Data_out[7:0] into a 4-entry FIFO; Data_out[15:8] ignored.
REQ-017 A TXDATA write while the FIFO is full and no pop occurs in the same cycle SHALL be dropped and SHALL set sticky OVF.
REQ-018 A push and a pop in the same cycle SHALL both succeed (count unchanged), including when full.
REQ-019 FIFO pointers SHALL be 2-bit and wrap 3 -> 0; count SHALL be 3-bit (0..4).
REQ-020 STATUS SHALL be {9'b0, OVF[6], COUNT[5:3], BUSY[2], EMPTY[1], FULL[0]}; BUSY = FSM not in IDLE.
REQ-021 CTRL SHALL be {14'b0, CLR_OVF[1], EN[0]}; CLR_OVF write-1 clears OVF, reads 0; OVF set and clear in the same cycle: set wins.
REQ-022 The FSM SHALL have states IDLE, START, DATA, STOP; frame SHALL be 8N1, LSB first.
REQ-023 IDLE: Tx=1; if EN & !EMPTY, pop head into shift register, load bit timer, go to START.
REQ-024 START: Tx=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
REQ-025 DATA: Tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right; after bit 7 go to STOP.
REQ-026 STOP: Tx=1 for CLKS_PER_BIT cycles; at end, if EN & !EMPTY pop and go directly to START (no idle gap), else IDLE.
REQ-027 Tx SHALL be driven from a register (glitch-free).
REQ-028 Latency: TXDATA write at edge N with FIFO empty and FSM IDLE, EN=1 -> pop and Tx falls after edge N+1.
REQ-029 A frame SHALL last exactly 10*CLKS_PER_BIT cycles from Tx falling edge to end of stop bit.
REQ-030 Clearing EN mid-frame SHALL let the current frame complete; no further pops until EN=1.
REQ-031 Writes to TXDATA SHALL be accepted regardless of EN.

Reset
REQ-032 Reset low SHALL immediately force: Tx=1, FSM=IDLE, FIFO empty (pointers 0, COUNT 0), OVF=0, EN=0, bit timer and shift register 0.
REQ-033 Reset asserted mid-frame SHALL abort the frame with Tx high at once; queued bytes SHALL be discarded.
REQ-034 After reset release, STATUS SHALL read 16'h0002 and CTRL 16'h0000.

Verification (CLKS_PER_BIT=4, BASE_ADDR=12'hFF0)
REQ-035 Reset then Rd at FF1 -> Data_in=16'h0002, Sel=1; Rd at 123 -> Data_in=0, Sel=0.
REQ-036 Write CTRL=1, write TXDATA=16'h12A5 -> Tx low 1 cycle after write, bits 1,0,1,0,0,1,0,1 at 4 cycles each, stop high, 40 cycles total, BUSY then 0.
REQ-037 EN=0, write 5 bytes 01..05 -> STATUS=16'h0061 (OVF, COUNT=4, FULL); write CTRL=3 -> OVF cleared, EN set, frames 01,02,03,04 back-to-back (160 cycles, no gap), 05 never sent.
REQ-038 FIFO full, transmitter popping: TXDATA write in pop cycle -> accepted, COUNT stays 4, OVF stays 0.
REQ-039 Clear EN during DATA of frame 1 with 2 queued -> frame 1 completes, Tx stays high, COUNT=2.
REQ-040 Assert Reset during DATA bit 3 -> Tx=1 same cycle, STATUS=16'h0002 after release, no further frame.

Source files
------------

// File: rtl/mu0_uart_tx.sv
`default_nettype none
// ============================================================================
// mu0_uart_tx : MU0 bus peripheral, 8N1 serial transmitter with 4-entry FIFO
// Revision    : 1.0
// ============================================================================
module mu0_uart_tx #(
  parameter int          CLKS_PER_BIT = 16,
  parameter logic [11:0] BASE_ADDR    = 12'hFF0
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [11:0] Address,
  input  logic [15:0] Data_out,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] Data_in,
  output logic        Sel,
  output logic        Tx
);

  localparam logic [1:0]  S_IDLE       = 2'd0;
  localparam logic [1:0]  S_START      = 2'd1;
  localparam logic [1:0]  S_DATA       = 2'd2;
  localparam logic [1:0]  S_STOP       = 2'd3;
  localparam logic [1:0]  C_REG_TXDATA = 2'd0;
  localparam logic [1:0]  C_REG_STATUS = 2'd1;
  localparam logic [1:0]  C_REG_CTRL   = 2'd2;
  localparam logic [15:0] C_BIT_LAST   = 16'(CLKS_PER_BIT - 1);

  logic [1:0]  r_state;
  logic [1:0]  w_state_next;
  logic [15:0] r_bit_timer;
  logic [15:0] w_bit_timer_next;
  logic [7:0]  r_shift;
  logic [7:0]  w_shift_next;
  logic [2:0]  r_bit_idx;
  logic [2:0]  w_bit_idx_next;
  logic        r_tx;
  logic        w_tx_next;
  logic [7:0]  r_fifo [4];
  logic [1:0]  r_wr_ptr;
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic        r_ovf;
  logic        r_en;
  logic        w_sel;
  logic        w_wr;
  logic        w_push_req;
  logic        w_push;
  logic        w_pop;
  logic        w_drop;
  logic        w_clr_ovf;
  logic        w_empty;
  logic        w_full;
  logic        w_busy;
  logic        w_timer_done;
  logic        w_unused_data;

  assign w_sel         = (Address[11:2] == BASE_ADDR[11:2]);
  assign Sel           = w_sel;
  assign w_wr          = Wr & w_sel;
  assign w_empty       = (r_count == 3'd0);
  assign w_full        = (r_count == 3'd4);
  assign w_busy        = (r_state != S_IDLE);
  assign w_timer_done  = (r_bit_timer == 16'd0);
  assign w_push_req    = w_wr && (Address[1:0] == C_REG_TXDATA);
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push        = w_push_req && (!w_full || w_pop);
  assign w_drop        = w_push_req && w_full && !w_pop;
  assign w_clr_ovf     = w_wr && (Address[1:0] == C_REG_CTRL) && Data_out[1];
  assign w_unused_data = &{1'b0, Data_out[15:8]};
  assign Tx            = r_tx;

  // State register and transmit datapath
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_bit_timer <= '0;
      r_shift     <= '0;
      r_bit_idx   <= '0;
      r_tx        <= 1'b1;
    end else begin
      r_state     <= w_state_next;
      r_bit_timer <= w_bit_timer_next;
      r_shift     <= w_shift_next;
      r_bit_idx   <= w_bit_idx_next;
      r_tx        <= w_tx_next;
    end
  end

  // Next-state logic; a pop is only ever taken on entry to START
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en && !w_empty) begin
          w_state_next = S_START;
          w_pop        = 1'b1;
        end
      end
      S_START: begin
        if (w_timer_done) w_state_next = S_DATA;
      end
      S_DATA: begin
        if (w_timer_done && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
      end
      S_STOP: begin
        if (w_timer_done) begin
          if (r_en && !w_empty) begin
            w_state_next = S_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: Tx is computed from the next state so it registers glitch-free
  always_comb begin
    w_bit_timer_next = r_bit_timer;
    w_shift_next     = r_shift;
    w_bit_idx_next   = r_bit_idx;
    if (w_pop) begin
      w_shift_next     = r_fifo[r_rd_ptr];
      w_bit_timer_next = C_BIT_LAST;
      w_bit_idx_next   = 3'd0;
    end else if (r_state != S_IDLE) begin
      if (w_timer_done) begin
        w_bit_timer_next = C_BIT_LAST;
        if (r_state == S_DATA) begin
          w_shift_next   = r_shift >> 1;
          w_bit_idx_next = r_bit_idx + 3'd1;
        end
      end else begin
        w_bit_timer_next = r_bit_timer - 16'd1;
      end
    end
    case (w_state_next)
      S_START: w_tx_next = 1'b0;
      S_DATA:  w_tx_next = w_shift_next[0];
      default: w_tx_next = 1'b1;
    endcase
  end

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count
  always_ff @(posedge Clk) begin
    if (w_push) r_fifo[r_wr_ptr] <= Data_out[7:0];
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_en     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 2'd1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 2'd1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
      if (w_wr && (Address[1:0] == C_REG_CTRL)) r_en <= Data_out[0];
    end
  end

  always_comb begin
    Data_in = 16'h0000;
    if (Rd && w_sel) begin
      case (Address[1:0])
        C_REG_STATUS: Data_in = {9'b0, r_ovf, r_count, w_busy, w_empty, w_full};
        C_REG_CTRL:   Data_in = {15'b0, r_en};
        default:      Data_in = 16'h0000;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mu0_uart_tx.sv
`default_nettype none
// tb_mu0_uart_tx : bench with a serial-line receiver monitor and a byte-queue
// model of the FIFO / STATUS register.
module tb_mu0_uart_tx;

  localparam int          C    = 4;
  localparam logic [11:0] BASE = 12'hFF0;
  localparam logic [11:0] A_TX = 12'hFF0;
  localparam logic [11:0] A_ST = 12'hFF1;
  localparam logic [11:0] A_CT = 12'hFF2;
  localparam logic [11:0] A_RS = 12'hFF3;

  logic        Clk      = 1'b0;
  logic        Reset    = 1'b0;
  logic [11:0] Address  = 12'h000;
  logic [15:0] Data_out = 16'h0000;
  logic        Rd       = 1'b0;
  logic        Wr       = 1'b0;
  logic [15:0] Data_in;
  logic        Sel;
  logic        Tx;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  byte unsigned rx_bytes[$];
  int           rx_fall[$];
  int           rx_bad   = 0;
  int           rx_abort = 0;
  byte unsigned model_q[$];
  bit           model_ovf = 1'b0;

  mu0_uart_tx #(.CLKS_PER_BIT(C), .BASE_ADDR(BASE)) dut (
    .Clk(Clk), .Reset(Reset), .Address(Address), .Data_out(Data_out),
    .Rd(Rd), .Wr(Wr), .Data_in(Data_in), .Sel(Sel), .Tx(Tx)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Serial receiver: each bit must hold its level for exactly C samples
  initial begin : monitor
    int         fall;
    bit         ok;
    bit         ab;
    logic [9:0] lv;
    forever begin
      @(negedge Clk);
      if (Reset === 1'b1 && Tx === 1'b0) begin
        fall = cyc; ok = 1'b1; ab = 1'b0; lv = '0;
        for (int k = 0; k < 10 && !ab; k++) begin
          for (int j = 0; j < C && !ab; j++) begin
            if (k != 0 || j != 0) @(negedge Clk);
            if (Reset !== 1'b1)   ab = 1'b1;
            else if (j == 0)      lv[k] = Tx;
            else if (Tx !== lv[k]) ok = 1'b0;
          end
        end
        if (ab) rx_abort++;
        else begin
          if (lv[0] !== 1'b0 || lv[9] !== 1'b1) ok = 1'b0;
          if (!ok) rx_bad++;
          rx_bytes.push_back(lv[8:1]);
          rx_fall.push_back(fall);
        end
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic check(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(logic [11:0] a, logic [15:0] d);
    Address = a; Data_out = d; Wr = 1'b1;
    tick();
    Wr = 1'b0; Address = 12'h000; Data_out = 16'h0000;
  endtask

  task automatic rd(logic [11:0] a, output logic [15:0] d, output logic s);
    Address = a; Rd = 1'b1;
    #1;
    d = Data_in; s = Sel;
    Rd = 1'b0; Address = 12'h000;
  endtask

  function automatic logic [15:0] exp_status(bit busy);
    int n = model_q.size();
    return {9'b0, model_ovf, 3'(n), busy, (n == 0), (n == 4)};
  endfunction

  task automatic model_push(byte unsigned b);
    if (model_q.size() < 4) model_q.push_back(b);
    else model_ovf = 1'b1;
  endtask

  task automatic wait_frames(int n, int budget, string tag);
    int t = 0;
    while (rx_bytes.size() < n && t < budget) begin tick(); t++; end
    check({tag, "_count"}, 16'(rx_bytes.size()), 16'(n));
  endtask

  task automatic check_frames(string tag);
    for (int i = 0; i < model_q.size() && i < rx_bytes.size(); i++) begin
      check({tag, "_byte"}, 16'(rx_bytes[i]), 16'(model_q[i]));
      if (i > 0) check({tag, "_gap"}, 16'(rx_fall[i] - rx_fall[i-1]), 16'(10 * C));
    end
    check({tag, "_framing"}, 16'(rx_bad), 16'h0000);
    model_q.delete(); rx_bytes.delete(); rx_fall.delete();
  endtask

  initial begin : stim
    logic [15:0]  d;
    logic         s;
    int           wc;
    int           n;
    bit           clr;
    byte unsigned b;
    byte unsigned p0;

    // Reset state, register window decode
    tick(3);
    check("tx_in_reset", 16'(Tx), 16'h0001);
    rd(A_ST, d, s); check("status_in_reset", d, 16'h0002);
    Reset = 1'b1;
    tick(2);
    rd(A_ST, d, s); check("status_after_reset", d, 16'h0002); check("sel_in_window", 16'(s), 16'h0001);
    rd(A_CT, d, s); check("ctrl_after_reset", d, 16'h0000);
    rd(12'h123, d, s); check("rd_outside_data", d, 16'h0000); check("rd_outside_sel", 16'(s), 16'h0000);
    for (int i = 0; i < 3; i++) begin
      rd(12'($urandom_range(0, 12'hFEF)), d, s);
      check("rand_outside_data", d, 16'h0000); check("rand_outside_sel", 16'(s), 16'h0000);
    end

    // Single frame: latency, bit order, frame length
    wr(A_CT, 16'h0001);
    rd(A_CT, d, s); check("ctrl_en", d, 16'h0001);
    wr(A_TX, 16'h12A5);
    wc = cyc;
    check("tx_high_at_write", 16'(Tx), 16'h0001);
    tick();
    check("tx_falls_next", 16'(Tx), 16'h0000);
    tick(39);
    rd(A_ST, d, s); check("busy_last_cycle", d, 16'h0006);
    tick();
    rd(A_ST, d, s); check("idle_after_40", d, 16'h0002);
    wait_frames(1, 5, "single");
    check("fall_latency", 16'(rx_fall[0]), 16'(wc + 1));
    model_q.push_back(8'hA5);
    check_frames("single");

    b = 8'($urandom);
    wr(A_TX, {8'($urandom), b});
    model_q.push_back(b);
    wait_frames(1, 60, "rand_single");
    check_frames("rand_single");
    tick(2);

    // Overflow with EN=0, then back-to-back drain
    wr(A_CT, 16'h0000);
    for (int i = 1; i <= 5; i++) begin
      wr(A_TX, 16'(i));
      model_push(8'(i));
    end
    rd(A_ST, d, s); check("status_full_ovf", d, 16'h0061);
    wr(A_CT, 16'h0003);
    model_ovf = 1'b0;
    rd(A_CT, d, s); check("ctrl_clr_reads0", d, 16'h0001);
    rd(A_ST, d, s); check("status_ovf_cleared", d, exp_status(1'b0));
    wait_frames(4, 4 * 40 + 20, "drain4");
    check_frames("drain4");
    tick(60);
    check("no_fifth_frame", 16'(rx_bytes.size()), 16'h0000);
    rd(A_ST, d, s); check("status_drained", d, 16'h0002);

    // Push into a full FIFO in the very cycle the transmitter pops
    wr(A_CT, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom); wr(A_TX, {8'h00, b}); model_push(b);
    end
    wr(A_CT, 16'h0001);
    b = 8'($urandom);
    wr(A_TX, {8'h00, b});
    model_q.push_back(b);
    rd(A_ST, d, s); check("push_on_pop", d, 16'h0025);
    wait_frames(5, 5 * 40 + 20, "push_on_pop");
    check_frames("push_on_pop");
    tick(2);

    // Randomised bursts with optional overflow clear
    for (int it = 0; it < 4; it++) begin
      wr(A_CT, 16'h0000);
      n = $urandom_range(0, 6);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom); wr(A_TX, {8'($urandom), b}); model_push(b);
      end
      rd(A_ST, d, s); check("rand_status_loaded", d, exp_status(1'b0));
      clr = 1'($urandom_range(0, 1));
      wr(A_CT, {14'b0, clr, 1'b1});
      if (clr) model_ovf = 1'b0;
      rd(A_CT, d, s); check("rand_ctrl", d, 16'h0001);
      n = model_q.size();
      wait_frames(n, n * 40 + 20, "rand_burst");
      check_frames("rand_burst");
      tick(2);
      rd(A_ST, d, s); check("rand_status_idle", d, exp_status(1'b0));
      wr(A_RS, 16'($urandom));
      rd(A_RS, d, s); check("reserved_reads0", d, 16'h0000);
      wr(A_CT, 16'h0002);
      model_ovf = 1'b0;
    end

    // Clear EN mid-frame: current frame completes, rest stays queued
    for (int i = 0; i < 3; i++) begin
      b = 8'($urandom); wr(A_TX, {8'h00, b}); model_push(b);
    end
    p0 = model_q[0];
    wr(A_CT, 16'h0001);
    tick(10);
    wr(A_CT, 16'h0000);
    wait_frames(1, 60, "en_clear");
    tick(20);
    check("en_clear_frames", 16'(rx_bytes.size()), 16'h0001);
    check("en_clear_byte", 16'(rx_bytes[0]), 16'(p0));
    check("en_clear_tx", 16'(Tx), 16'h0001);
    void'(model_q.pop_front());
    rd(A_ST, d, s); check("en_clear_status", d, exp_status(1'b0));
    rx_bytes.delete(); rx_fall.delete();

    // Reset during data bit 3 aborts the frame and discards the queue
    wr(A_CT, 16'h0001);
    tick();
    tick(17);
    check("bit3_level", 16'(Tx), 16'(model_q[0][3]));
    #2 Reset = 1'b0;
    #1 check("tx_high_on_reset", 16'(Tx), 16'h0001);
    rd(A_ST, d, s); check("status_during_reset", d, 16'h0002);
    tick(2);
    Reset = 1'b1;
    model_q.delete(); model_ovf = 1'b0;
    tick(2);
    rd(A_ST, d, s); check("status_post_reset", d, 16'h0002);
    rd(A_CT, d, s); check("ctrl_post_reset", d, 16'h0000);
    wr(A_CT, 16'h0001);
    tick(100);
    check("no_frame_after_reset", 16'(rx_bytes.size()), 16'h0000);
    check("aborted_frames", 16'(rx_abort), 16'h0001);
    rd(A_ST, d, s); check("status_final", d, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
